// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: one READ and one WRITE cycle per word, done pulses in cycle 2*len+1.
// Define MEM_COPY_CHECKSUM_EN to build the running 32-bit sum of copied words on checksum.
module mem_copy_dma #(
  parameter int IDX_W = 10,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_base,
  input  logic [31:0]      dst_base,
  input  logic [LEN_W-1:0] len,
  output logic [31:0]      address,
  output logic [31:0]      writedata,
  output logic             writemem,
  output logic             readmem,
  input  logic [31:0]      readmem_out,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  // Masking the full 32-bit sum gives the index wrap and keeps upper address bits at zero.
  localparam logic [31:0] IDX_MASK = 32'((64'd1 << IDX_W) - 64'd1);

  state_t           state_q, state_d;
  logic [31:0]      src_q, dst_q, data_q;
  logic [LEN_W-1:0] len_q, i_q;
  logic             start_ok, last_word;

  assign start_ok  = (state_q == IDLE) && start;
  assign last_word = (i_q == len_q - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    address   = '0;
    writedata = '0;
    writemem  = 1'b0;
    readmem   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = (len == '0) ? DONE : READ;
      end
      READ: begin
        address = (src_q + 32'(i_q)) & IDX_MASK;
        readmem = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        address   = (dst_q + 32'(i_q)) & IDX_MASK;
        writedata = data_q;
        writemem  = 1'b1;
        state_d   = last_word ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      i_q    <= '0;
      data_q <= '0;
    end else begin
      if (start_ok) begin
        src_q <= src_base;
        dst_q <= dst_base;
        len_q <= len;
        i_q   <= '0;
      end
      if (state_q == READ)  data_q <= readmem_out;
      if (state_q == WRITE) i_q    <= i_q + LEN_W'(1);
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   sum_q <= '0;
    else if (start_ok)         sum_q <= '0;
    else if (state_q == READ)  sum_q <= sum_q + readmem_out;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter IDX_W, default 10: word-index width; the memory holds 2^IDX_W 32-bit words (1024).
REQ-002 Parameter LEN_W, default 11: width of the transfer-length input; the maximum length is 1024 words.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request to begin a copy; sampled only in IDLE.
REQ-006 Port src_base, input, 32 bits: word index of the first source word.
REQ-007 Port dst_base, input, 32 bits: word index of the first destination word.
REQ-008 Port len, input, LEN_W bits: number of words to copy.
REQ-009 Port address, output, 32 bits: memory word address.
REQ-010 Port writedata, output, 32 bits: memory write data.
REQ-011 Port writemem, output, 1 bit: memory write strobe; the memory commits the write at posedge clk.
REQ-012 Port readmem, output, 1 bit: memory read enable.
REQ-013 Port readmem_out, input, 32 bits: combinational memory read data, valid in the same cycle as address and readmem.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.
REQ-015 Port done, output, 1 bit: single-cycle completion pulse.
REQ-016 Port checksum, output, 32 bits: running sum of the copied words (see Configuration).

Function
REQ-017 The block shall implement four states: IDLE, READ, WRITE and DONE.
REQ-018 In IDLE with start=1, the block shall latch src_base, dst_base and len, clear its word counter i, and move to READ, or directly to DONE if len=0.
REQ-019 In READ, the block shall drive address={0,(src+i) mod 2^IDX_W} with readmem=1 and writemem=0, capture readmem_out into a data register at the clock edge, and move to WRITE.
REQ-020 In WRITE, the block shall drive address={0,(dst+i) mod 2^IDX_W}, writedata equal to the captured register, writemem=1 and readmem=0.
REQ-021 In WRITE, the block shall increment i and move to DONE if i=len-1, otherwise back to READ.
REQ-022 In DONE, the block shall hold done=1 for exactly one cycle and then return to IDLE.
REQ-023 The block shall drive done high in cycle 2*len+1 after the start-sampling edge (cycle 1 for len=0).
REQ-024 Outside READ and WRITE, the block shall drive address=0, writedata=0, writemem=0 and readmem=0.
REQ-025 The block shall never assert writemem and readmem in the same cycle.
REQ-026 The block shall ignore start while busy=1, without changing the latched operands.
REQ-027 Address arithmetic shall wrap modulo 2^IDX_W (e.g. src 1023 followed by 0), and the upper 32-IDX_W address bits shall always be 0.
REQ-028 Overlapping source and destination regions shall be copied in ascending index order with no hazard protection; the resulting memory contents follow directly from that order.
REQ-029 A len value greater than 2^IDX_W shall be treated as len mod 2^(LEN_W).

Reset
REQ-030 Asserting rst shall immediately, without waiting for a clock edge, set the state to IDLE and clear i, the data register and checksum.
REQ-031 While rst is asserted, the block shall drive busy=0, done=0, writemem=0, readmem=0, address=0 and writedata=0.
REQ-032 Reset asserted mid-copy shall abort the copy with no further writes; words already written shall remain written.
REQ-033 The first start after rst deasserts shall be honoured normally.

Configuration
REQ-034 When MEM_COPY_CHECKSUM_EN is defined, the block shall clear checksum on accepted start and add each captured word, modulo 2^32, at the READ edge.
REQ-035 When MEM_COPY_CHECKSUM_EN is defined, checksum shall be stable from DONE until the next accepted start.
REQ-036 When MEM_COPY_CHECKSUM_EN is undefined, checksum shall be tied to 0 and the accumulator logic shall be absent.
REQ-037 All other behaviour shall be identical with and without MEM_COPY_CHECKSUM_EN.

Verification
REQ-038 Preload M[1000..1004]={13,5,50,4,12}, then start src=1000, dst=0, len=5 -> M[0..4]={13,5,50,4,12}, done pulses in cycle 11, and checksum=84 with the macro defined (0 without).
REQ-039 Start with len=0 -> no writemem ever asserted, and done pulses in cycle 1 after start.
REQ-040 Preload M[1022]=7, M[1023]=8, M[0]=9, M[1]=10, then start src=1022, dst=500, len=4 -> read addresses 1022, 1023, 0, 1, M[500..503]={7,8,9,10}, and address[31:10]=0 throughout.
REQ-041 Pulse start with src=0 during a len=5 copy -> ignored, and the original copy completes unchanged.
REQ-042 Assert rst asynchronously, mid-cycle, during the third WRITE of a len=5 copy -> writemem drops immediately, only 2 destination words change, busy=0, and a following start copies correctly.
REQ-043 Check every cycle of all scenarios that writemem and readmem are never both 1.
